dmem_lsu: RTL and testbench

Parametrised data memory with an integrated load/store unit for the pipelined RISC-V core, sitting behind the MEM stage. It accepts one request per cycle over a valid/ready handshake. It performs byte, halfword and word stores with per-byte write enables, and returns loads after one cycle with sign or zero extension applied. Misaligned and illegal-size accesses are flagged instead of executed, and an internal FSM zeroes the whole array after reset before the block accepts any request.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_lsu_if.sv | 23 ++
 rtl/dmem_lane_align.sv | 47 ++++
 rtl/dmem_lsu.sv | 161 ++++++++++++++++
 tb/tb_dmem_lsu.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the dmem_lsu data memory / load-store unit.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  // Width of the word index into an array of depth_words 32-bit words.
  function automatic int addr_index_w(input int depth_words);
    return $clog2(depth_words);
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Request/response bus between the MEM stage (master) and dmem_lsu (slave).
interface dmem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: byte enables, replicated store data and
// misalignment flag for a given access size and byte offset.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic        misalign
);

  // Illegal size falls through to the defaults: no lanes, flagged misaligned.
  always_comb begin
    be        = 4'b0000;
    wdata_rep = 32'h0000_0000;
    misalign  = 1'b1;
    case (size)
      SZ_BYTE: begin
        be        = 4'b0001 << offset;
        wdata_rep = {4{wdata[7:0]}};
        misalign  = 1'b0;
      end
      SZ_HALF: begin
        if (offset[1]) begin
          be = 4'b1100;
        end else begin
          be = 4'b0011;
        end
        wdata_rep = {2{wdata[15:0]}};
        misalign  = offset[0];
      end
      SZ_WORD: begin
        be        = 4'b1111;
        wdata_rep = wdata;
        misalign  = (offset != 2'b00);
      end
      default: begin
        be        = 4'b0000;
        wdata_rep = 32'h0000_0000;
        misalign  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Data memory with load/store unit: clears itself after reset, then serves
// one byte/half/word request per cycle with a one-cycle response.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256
) (
  input logic       clk,
  input logic       rst,
  dmem_lsu_if.slave bus
);

  localparam int IW = addr_index_w(DEPTH_WORDS);

  state_e        state_q, state_d;
  logic [IW-1:0] clear_idx_q, clear_idx_d;
  logic          resp_valid_q, resp_valid_d;
  logic          resp_err_q, resp_err_d;
  logic          ld_q, ld_d;
  logic [1:0]    off_q, off_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;

  logic [31:0]   mem_q [DEPTH_WORDS];
  logic [31:0]   rd_word_q;

  logic          accept_s;
  logic [IW-1:0] req_idx_s;
  logic [3:0]    st_be_s;
  logic [31:0]   st_wdata_s;
  logic          st_misalign_s;
  logic [3:0]    mem_we_s;
  logic [IW-1:0] mem_widx_s;
  logic [31:0]   mem_wdata_s;

  logic [3:0]    ld_be_s;
  logic [31:0]   ld_wrep_unused_s;
  logic          ld_misalign_s;
  logic [31:0]   ld_lane_mask_s;
  logic [31:0]   ld_raw_s;
  logic [31:0]   resp_rdata_s;

  assign accept_s  = bus.req_valid && (state_q == ST_READY);
  assign req_idx_s = bus.req_addr[IW+1:2];

  dmem_lane_align u_st_align (
    .size      (bus.req_size),
    .offset    (bus.req_addr[1:0]),
    .wdata     (bus.req_wdata),
    .be        (st_be_s),
    .wdata_rep (st_wdata_s),
    .misalign  (st_misalign_s)
  );

  // Same lane logic on the registered request selects the bytes to extract.
  dmem_lane_align u_ld_align (
    .size      (size_q),
    .offset    (off_q),
    .wdata     (32'h0000_0000),
    .be        (ld_be_s),
    .wdata_rep (ld_wrep_unused_s),
    .misalign  (ld_misalign_s)
  );

  // Next-state, clear counter, RAM write port and response register inputs.
  always_comb begin
    state_d      = state_q;
    clear_idx_d  = clear_idx_q;
    mem_we_s     = 4'b0000;
    mem_widx_s   = req_idx_s;
    mem_wdata_s  = st_wdata_s;
    resp_valid_d = accept_s;
    resp_err_d   = accept_s && st_misalign_s;
    ld_d         = accept_s && !bus.req_we && !st_misalign_s;
    off_d        = bus.req_addr[1:0];
    size_d       = bus.req_size;
    uns_d        = bus.req_unsigned;
    case (state_q)
      ST_CLEAR: begin
        mem_we_s    = 4'b1111;
        mem_widx_s  = clear_idx_q;
        mem_wdata_s = 32'h0000_0000;
        clear_idx_d = clear_idx_q + IW'(1);
        if (clear_idx_q == IW'(DEPTH_WORDS - 1)) begin
          state_d = ST_READY;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      ST_READY: begin
        if (accept_s && bus.req_we && !st_misalign_s) begin
          mem_we_s = st_be_s;
        end else begin
          mem_we_s = 4'b0000;
        end
      end
      default: begin
        state_d     = ST_CLEAR;
        clear_idx_d = '0;
      end
    endcase
  end

  // Control and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_CLEAR;
      clear_idx_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      ld_q         <= 1'b0;
      off_q        <= 2'b00;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      clear_idx_q  <= clear_idx_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      ld_q         <= ld_d;
      off_q        <= off_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
    end
  end

  // Byte-write RAM with synchronous read port; contents are not reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_we_s[b]) begin
        mem_q[mem_widx_s][b*8 +: 8] <= mem_wdata_s[b*8 +: 8];
      end
    end
    rd_word_q <= mem_q[req_idx_s];
  end

  // Load extraction and extension on the registered read word.
  always_comb begin
    ld_lane_mask_s = {{8{ld_be_s[3]}}, {8{ld_be_s[2]}}, {8{ld_be_s[1]}}, {8{ld_be_s[0]}}};
    ld_raw_s       = (rd_word_q & ld_lane_mask_s) >> {off_q, 3'b000};
    resp_rdata_s   = 32'h0000_0000;
    if (ld_q && !ld_misalign_s) begin
      case (size_q)
        SZ_BYTE: resp_rdata_s = uns_q ? {24'h00_0000, ld_raw_s[7:0]}
                                      : {{24{ld_raw_s[7]}}, ld_raw_s[7:0]};
        SZ_HALF: resp_rdata_s = uns_q ? {16'h0000, ld_raw_s[15:0]}
                                      : {{16{ld_raw_s[15]}}, ld_raw_s[15:0]};
        SZ_WORD: resp_rdata_s = ld_raw_s;
        default: resp_rdata_s = 32'h0000_0000;
      endcase
    end else begin
      resp_rdata_s = 32'h0000_0000;
    end
  end

  assign bus.req_ready  = (state_q == ST_READY);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_s;

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: directed cases plus random traffic
// compared against a byte-array reference memory.
module tb_dmem_lsu;
  import dmem_pkg::*;

  localparam int DEPTH = 256;
  localparam int NBYTES = DEPTH * 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] ref_mem [NBYTES];

  dmem_lsu_if bus ();

  dmem_lsu #(.DEPTH_WORDS(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NBYTES; i++) ref_mem[i] = 8'h00;
  endtask

  // Reference load: little-endian byte assembly then extension.
  function automatic logic [31:0] model_load(input int a, input int n, input logic uns);
    logic [31:0] v;
    v = 32'h0000_0000;
    for (int i = 0; i < n; i++) v = v | (32'(ref_mem[a + i]) << (8 * i));
    if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  // One request at a negedge; response checked at the following negedge.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata, input string tag,
                       output logic [31:0] obs);
    int n;
    int a;
    logic exp_err;
    logic [31:0] exp_data;
    n = 1 << size;
    a = int'(addr) & (NBYTES - 1);
    exp_err = (size == 2'b11) || ((a % n) != 0);
    exp_data = 32'h0000_0000;
    if (!exp_err) begin
      if (we) begin
        for (int i = 0; i < n; i++) ref_mem[a + i] = wdata[8*i +: 8];
      end else begin
        exp_data = model_load(a, n, uns);
      end
    end
    check({tag, "_ready"}, {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_addr = addr;
    bus.req_size = size;
    bus.req_unsigned = uns;
    bus.req_wdata = wdata;
    @(negedge clk);
    bus.req_valid = 1'b0;
    obs = bus.resp_rdata;
    check({tag, "_valid"}, {31'd0, bus.resp_valid}, 32'd1);
    check({tag, "_err"}, {31'd0, bus.resp_err}, {31'd0, exp_err});
    check({tag, "_rdata"}, bus.resp_rdata, exp_data);
  endtask

  task automatic count_clear(input string tag);
    int cnt;
    cnt = 0;
    while (bus.req_ready !== 1'b1 && cnt < 2000) begin
      cnt++;
      @(negedge clk);
    end
    check(tag, cnt, DEPTH);
  endtask

  initial begin
    logic [31:0] obs;
    logic [31:0] addr;
    logic [1:0]  sz;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_addr = 32'h0;
    bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_wdata = 32'h0;
    model_clear();
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, bus.req_ready}, 32'd0);
    check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_resp_err", {31'd0, bus.resp_err}, 32'd0);
    rst = 1'b0;
    count_clear("clear_cycles");
    @(negedge clk);
    check("ready_after_clear", {31'd0, bus.req_ready}, 32'd1);

    issue(1'b0, 32'h3FC, SZ_WORD, 1'b0, 32'h0, "lw_3fc", obs);
    check("lw_3fc_lit", obs, 32'h0000_0000);
    issue(1'b1, 32'h10, SZ_WORD, 1'b0, 32'hDEADBEEF, "sw_10", obs);
    issue(1'b0, 32'h13, SZ_BYTE, 1'b0, 32'h0, "lb_13", obs);
    check("lb_13_lit", obs, 32'hFFFF_FFDE);
    issue(1'b0, 32'h13, SZ_BYTE, 1'b1, 32'h0, "lbu_13", obs);
    check("lbu_13_lit", obs, 32'h0000_00DE);
    issue(1'b0, 32'h10, SZ_HALF, 1'b0, 32'h0, "lh_10", obs);
    check("lh_10_lit", obs, 32'hFFFF_BEEF);
    issue(1'b0, 32'h12, SZ_HALF, 1'b1, 32'h0, "lhu_12", obs);
    check("lhu_12_lit", obs, 32'h0000_DEAD);
    issue(1'b1, 32'h11, SZ_BYTE, 1'b0, 32'hFFFF_FF55, "sb_11", obs);
    issue(1'b0, 32'h10, SZ_WORD, 1'b0, 32'h0, "lw_10a", obs);
    check("lw_10a_lit", obs, 32'hDEAD_55EF);
    issue(1'b1, 32'h12, SZ_HALF, 1'b0, 32'hABCD_1234, "sh_12", obs);
    issue(1'b0, 32'h10, SZ_WORD, 1'b0, 32'h0, "lw_10b", obs);
    check("lw_10b_lit", obs, 32'h1234_55EF);
    @(negedge clk);
    check("idle_valid", {31'd0, bus.resp_valid}, 32'd0);

    issue(1'b0, 32'h02, SZ_WORD, 1'b0, 32'h0, "lw_mis", obs);
    issue(1'b1, 32'h11, SZ_HALF, 1'b0, 32'h7777, "sh_mis", obs);
    issue(1'b0, 32'h10, SZ_WORD, 1'b0, 32'h0, "lw_10c", obs);
    check("lw_10c_lit", obs, 32'h1234_55EF);
    issue(1'b1, 32'h14, SZ_ILL, 1'b0, 32'h1111_1111, "sz_ill_st", obs);
    issue(1'b0, 32'h14, SZ_ILL, 1'b1, 32'h0, "sz_ill_ld", obs);
    issue(1'b0, 32'h14, SZ_WORD, 1'b0, 32'h0, "lw_14", obs);

    issue(1'b1, 32'h20, SZ_WORD, 1'b0, 32'hA5A5_A5A5, "b2b_sw", obs);
    issue(1'b0, 32'h20, SZ_WORD, 1'b0, 32'h0, "b2b_lw", obs);
    check("b2b_lw_lit", obs, 32'hA5A5_A5A5);
    issue(1'b1, 32'h420, SZ_WORD, 1'b0, 32'h0BAD_F00D, "alias_sw", obs);
    issue(1'b0, 32'h20, SZ_WORD, 1'b0, 32'h0, "alias_lw", obs);
    check("alias_lw_lit", obs, 32'h0BAD_F00D);

    for (int k = 0; k < 300; k++) begin
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr[9:0] = 10'($urandom_range(0, 63));
      sz = 2'($urandom_range(0, 3));
      issue(1'($urandom_range(0, 1)), addr, sz, 1'($urandom_range(0, 1)), $urandom, "rand", obs);
      if ($urandom_range(0, 4) == 0) @(negedge clk);
    end

    bus.req_valid = 1'b1;
    bus.req_we = 1'b0;
    bus.req_addr = 32'h10;
    bus.req_size = SZ_WORD;
    rst = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("rst_drops_valid", {31'd0, bus.resp_valid}, 32'd0);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check("midclear_ready", {31'd0, bus.req_ready}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    count_clear("midclear_restart_cycles");
    model_clear();
    issue(1'b0, 32'h10, SZ_WORD, 1'b0, 32'h0, "post_clear_lw_10", obs);
    check("post_clear_lw_10_lit", obs, 32'h0000_0000);
    issue(1'b0, 32'h20, SZ_WORD, 1'b0, 32'h0, "post_clear_lw_20", obs);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
